// File: rtl/acc_register_stack.sv
// Accumulator register with status flags and a DEPTH-entry save/restore stack.
// Optional build macro ACC_STACK_SAT_EN: INC/DEC saturate instead of wrapping.
module acc_register_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic [2:0]       op,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      OP_HOLD  = 3'b000,
      OP_LOAD  = 3'b001,
      OP_CLEAR = 3'b010,
      OP_SET   = 3'b011,
      OP_INC   = 3'b100,
      OP_DEC   = 3'b101,
      OP_SHL   = 3'b110,
      OP_SHR   = 3'b111
   } op_t;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] op_q;
   logic             op_c;
   logic [WIDTH:0]   inc_sum;
   logic [WIDTH:0]   dec_diff;
   logic [CW-1:0]    count_m1;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    top_idx;

   assign zero     = (q == '0);
   assign negative = q[WIDTH-1];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

   assign count_m1 = count - CW'(1);
   assign wr_idx   = count[AW-1:0];
   assign top_idx  = count_m1[AW-1:0];

   // Extra MSB holds the carry out of INC and the borrow out of DEC.
   assign inc_sum  = {1'b0, q} + (WIDTH+1)'(1);
   assign dec_diff = {1'b0, q} - (WIDTH+1)'(1);

   always_comb begin
      op_q = q;
      op_c = carry;
      case (op_t'(op))
         OP_HOLD:  begin op_q = q;          op_c = carry;    end
         OP_LOAD:  begin op_q = d;          op_c = 1'b0;     end
         OP_CLEAR: begin op_q = '0;         op_c = 1'b0;     end
         OP_SET:   begin op_q = '1;         op_c = 1'b0;     end
`ifdef ACC_STACK_SAT_EN
         OP_INC: begin
            op_q = (&q) ? q : inc_sum[WIDTH-1:0];
            op_c = inc_sum[WIDTH];
         end
         OP_DEC: begin
            op_q = (q == '0) ? q : dec_diff[WIDTH-1:0];
            op_c = dec_diff[WIDTH];
         end
`else
         OP_INC:   begin op_q = inc_sum[WIDTH-1:0];  op_c = inc_sum[WIDTH];  end
         OP_DEC:   begin op_q = dec_diff[WIDTH-1:0]; op_c = dec_diff[WIDTH]; end
`endif
         OP_SHL:   begin op_q = {q[WIDTH-2:0], 1'b0}; op_c = q[WIDTH-1]; end
         OP_SHR:   begin op_q = {1'b0, q[WIDTH-1:1]}; op_c = q[0];       end
         default:  begin op_q = q;          op_c = carry;    end
      endcase
   end

   // pop has priority over op; push+pop on a non-empty stack swaps q with the top entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q         <= '0;
         carry     <= 1'b0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         if (pop) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               q <= mem[top_idx];
               if (!push) count <= count_m1;
            end
         end else begin
            q     <= op_q;
            carry <= op_c;
            if (push) begin
               if (full) overflow <= 1'b1;
               else      count    <= count + CW'(1);
            end
         end
      end
   end

   // Stack storage is intentionally not reset.
   always_ff @(posedge clock) begin
      if (push && pop && !empty) begin
         mem[top_idx] <= q;
      end else if (push && !pop && !full) begin
         mem[wr_idx] <= q;
      end
   end

endmodule
